// File: rtl/step_sequencer.sv
// Instruction phase controller: IDLE -> FETCH -> EXEC -> DONE, with one step index issued per execute cycle.
// Optional single-step gating of EXEC via `define STEP_SINGLE_STEP_EN (adds step_go input).
module step_sequencer #(
  parameter int CNT_W     = 4,
  parameter int FETCH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             hold,
  input  logic             abort,
`ifdef STEP_SINGLE_STEP_EN
  input  logic             step_go,
`endif
  output logic             ready,
  output logic             busy,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] step,
  output logic             step_valid,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] exec_last;
  logic             exec_adv;

  assign exec_last = len_q - CNT_W'(1);

`ifdef STEP_SINGLE_STEP_EN
  assign exec_adv = step_go && !hold;
`else
  assign exec_adv = !hold;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      step  <= '0;
      len_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            len_q <= len;
            step  <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (abort) begin
            state <= S_IDLE;
            step  <= '0;
          end else if (!hold) begin
            if (step == FETCH_LAST) begin
              // Counter is cleared on every phase exit, so DONE always shows step=0.
              step  <= '0;
              state <= (len_q == '0) ? S_DONE : S_EXEC;
            end else begin
              step <= step + CNT_W'(1);
            end
          end
        end
        S_EXEC: begin
          if (abort) begin
            state <= S_IDLE;
            step  <= '0;
          end else if (exec_adv) begin
            if (step == exec_last) begin
              step  <= '0;
              state <= S_DONE;
            end else begin
              step <= step + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          step  <= '0;
        end
        default: begin
          state <= S_IDLE;
          step  <= '0;
        end
      endcase
    end
  end

  assign ready      = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign phase      = state;
  assign step_valid = (state == S_EXEC) && exec_adv;
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer; a schedule-queue model predicts every output each cycle.
module tb_step_sequencer;
  localparam int CNT_W     = 4;
  localparam int FETCH_CYC = 2;

  logic             clk = 1'b0;
  logic             rst, start, hold, abort;
  logic [CNT_W-1:0] len;
  logic             ready, busy, done, step_valid;
  logic [1:0]       phase;
  logic [CNT_W-1:0] step;
`ifdef STEP_SINGLE_STEP_EN
  logic             step_go = 1'b1;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int busy_cnt, done_cnt, valid_cnt, max_step;

  step_sequencer #(.CNT_W(CNT_W), .FETCH_CYC(FETCH_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .hold(hold), .abort(abort),
`ifdef STEP_SINGLE_STEP_EN
    .step_go(step_go),
`endif
    .ready(ready), .busy(busy), .phase(phase), .step(step),
    .step_valid(step_valid), .done(done)
  );

  always #5 clk = ~clk;

  // Model: an accepted instruction becomes a list of (phase, step) cycles;
  // hold stalls the head in FETCH/EXEC, abort/rst drop the list, empty = IDLE.
  typedef struct { int ph; int st; } ent_t;
  ent_t sched[$];

  always @(posedge clk) begin
    if (rst) begin
      sched.delete();
    end else if (sched.size() == 0) begin
      if (start) begin
        for (int i = 0; i < FETCH_CYC; i++) sched.push_back('{1, i});
        for (int i = 0; i < int'(len); i++) sched.push_back('{2, i});
        sched.push_back('{3, 0});
      end
    end else if (abort) begin
      sched.delete();
    end else if (!(hold && (sched[0].ph == 1 || sched[0].ph == 2))) begin
      void'(sched.pop_front());
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      ent_t e;
      e = (sched.size() == 0) ? '{0, 0} : sched[0];
      check("ready", 8'(ready), 8'(e.ph == 0));
      check("busy", 8'(busy), 8'(e.ph != 0));
      check("phase", 8'(phase), 8'(e.ph));
      check("step", 8'(step), 8'(e.st));
      check("step_valid", 8'(step_valid), 8'(e.ph == 2 && !hold));
      check("done", 8'(done), 8'(e.ph == 3));
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (step_valid === 1'b1) begin
        valid_cnt++;
        if (int'(step) > max_step) max_step = int'(step);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts;
    busy_cnt = 0; done_cnt = 0; valid_cnt = 0; max_step = -1;
  endtask

  task automatic issue(input int l);
    len = CNT_W'(l); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; len = '0;
    clear_counts();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    // Reset then idle
    tick(5);
    check("lit_idle_busy", 8'(busy_cnt), 8'd0);
    check("lit_idle_step", 8'(step), 8'd0);

    // Normal run, len=3
    clear_counts();
    issue(3);
    tick(9);
    check("lit_norm_busy", 8'(busy_cnt), 8'd6);
    check("lit_norm_valid", 8'(valid_cnt), 8'd3);
    check("lit_norm_done", 8'(done_cnt), 8'd1);
    check("lit_norm_max", 8'(max_step), 8'd2);

    // Zero length
    clear_counts();
    issue(0);
    tick(6);
    check("lit_zero_busy", 8'(busy_cnt), 8'd3);
    check("lit_zero_valid", 8'(valid_cnt), 8'd0);
    check("lit_zero_done", 8'(done_cnt), 8'd1);

    // Hold for 3 cycles at EXEC step 1
    clear_counts();
    issue(4);
    tick(3);
    hold = 1'b1;
    tick(3);
    hold = 1'b0;
    tick(8);
    check("lit_hold_busy", 8'(busy_cnt), 8'd10);
    check("lit_hold_valid", 8'(valid_cnt), 8'd4);
    check("lit_hold_done", 8'(done_cnt), 8'd1);

    // Abort together with hold at EXEC step 2
    clear_counts();
    issue(5);
    tick(4);
    abort = 1'b1; hold = 1'b1;
    tick();
    abort = 1'b0; hold = 1'b0;
    tick(4);
    check("lit_abort_busy", 8'(busy_cnt), 8'd5);
    check("lit_abort_done", 8'(done_cnt), 8'd0);

    // rst mid-FETCH
    clear_counts();
    issue(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(4);
    check("lit_rst_busy", 8'(busy_cnt), 8'd1);

    // abort+start in IDLE is accepted; abort in DONE returns to IDLE
    clear_counts();
    abort = 1'b1;
    issue(0);
    abort = 1'b0;
    tick(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(3);
    check("lit_abst_busy", 8'(busy_cnt), 8'd3);
    check("lit_abst_done", 8'(done_cnt), 8'd1);

    // Max length with ignored start during EXEC
    clear_counts();
    issue(15);
    tick(5);
    len = CNT_W'(2); start = 1'b1;
    tick();
    start = 1'b0;
    tick(24);
    check("lit_max_busy", 8'(busy_cnt), 8'd18);
    check("lit_max_valid", 8'(valid_cnt), 8'd15);
    check("lit_max_done", 8'(done_cnt), 8'd1);
    check("lit_max_step", 8'(max_step), 8'd14);

    // Back-to-back: start held high, len=1
    clear_counts();
    len = CNT_W'(1); start = 1'b1;
    tick(10);
    start = 1'b0;
    tick(6);
    check("lit_b2b_done", 8'(done_cnt), 8'd2);
    check("lit_b2b_busy", 8'(busy_cnt), 8'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Multi-cycle instruction phase controller for the FSM processor.
- Owns a 4-bit step counter and sequences it through fetch and execute phases.
- Issues one execute step index per cycle to the datapath.
- Sits between the instruction issue logic (start/len handshake) and the datapath decoders, which consume phase/step/step_valid.

Parameters:
- CNT_W, 4, width of step counter and len input; max execute length 2^CNT_W-1.
- FETCH_CYC, 2, number of fetch-phase cycles; legal range 1..2^CNT_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request new instruction; sampled only when ready=1
- len  input  CNT_W  number of execute steps for the requested instruction; captured with start
- hold  input  1  stall; freezes counter and state in FETCH/EXEC
- abort  input  1  cancel current instruction
- ready  output  1  high in IDLE only
- busy  output  1  high in FETCH, EXEC, DONE
- phase  output  2  00 IDLE, 01 FETCH, 10 EXEC, 11 DONE
- step  output  CNT_W  current counter value
- step_valid  output  1  an execute step is issued this cycle
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset: a synchronous rst=1 at a clock edge sets state IDLE, step=0 and len_q=0; rst overrides all other inputs.
- Outputs after reset: ready=1, busy=0, phase=00, step=0, step_valid=0, done=0.
- Output decoding: all outputs are Moore, decoded from registered state, counter and len_q. No input-to-output combinational paths, except step_valid, which is also gated by hold.
- IDLE:
  - start=1 captures len into len_q, clears step to 0 and moves to FETCH on the next edge.
  - start=0 stays in IDLE. hold is ignored in IDLE.
- FETCH:
  - step counts 0..FETCH_CYC-1, one per unheld cycle.
  - On an unheld cycle with step==FETCH_CYC-1: if len_q==0, go to DONE; otherwise go to EXEC with step=0.
- EXEC:
  - step_valid = !hold.
  - step advances +1 per unheld cycle.
  - On an unheld cycle with step==len_q-1, go to DONE. The last step is issued with step_valid=1 in that cycle.
- DONE:
  - Lasts exactly one cycle with done=1, then returns to IDLE with step=0.
  - hold is ignored in DONE.
- Counter rules:
  - Arithmetic is modulo 2^CNT_W.
  - The terminal compare always precedes any wrap, so no wrap occurs in legal operation.
  - len=15 yields steps 0..15-1=14.
- hold: in FETCH/EXEC, state and step are unchanged and step_valid=0. Multi-cycle holds are legal.
- abort:
  - In FETCH/EXEC/DONE, go to IDLE and clear step to 0 on the next edge, with no done pulse.
  - abort has priority over hold and over terminal-step transitions.
  - abort is ignored in IDLE.
  - abort and start asserted together in IDLE: start is accepted.
- start while busy=1 is ignored and not queued.
- Back-to-back: start may be asserted during DONE, but it is not sampled until ready=1 the following cycle. Minimum issue interval is FETCH_CYC+len+2 cycles.

Optional Feature:
- Macro: STEP_SINGLE_STEP_EN.
- Defined:
  - Adds input port step_go (1 bit) after abort.
  - In EXEC, step advances and step_valid asserts only when step_go=1 && !hold.
  - FETCH is unaffected.
  - abort still has priority.
- Undefined: no step_go port; EXEC advances on every unheld cycle as described above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> ready=1, phase=00, step=0, done=0. With start=0 held for 5 cycles, outputs are unchanged.
- Normal run: start=1, len=3, hold=0 ->
  - FETCH for 2 cycles (step 0,1).
  - EXEC for 3 cycles (step 0,1,2 with step_valid=1).
  - DONE for 1 cycle (done=1), then IDLE.
  - Total busy = 6 cycles.
- Zero length: start=1, len=0 -> FETCH 2 cycles, then DONE with step_valid never asserted, then ready=1.
- Hold: len=4, hold=1 for 3 cycles while in EXEC at step=1 -> step stays 1 with step_valid=0 during the hold. The run resumes at step 2 and done asserts 3 cycles later than unheld.
- Abort/priority:
  - abort=1 together with hold=1 in EXEC step=2 -> next cycle phase=00, step=0, with no done pulse.
  - rst=1 mid-FETCH -> IDLE the next cycle.
- Maximum length plus ignored start: len=15 -> steps 0..14 issued with no wrap, done=1 once. A start pulse during EXEC is ignored (len_q unchanged).
